// File: rtl/mprj_wb_guard_if.sv
// Wishbone classic bus bundle used on both sides of the guard.
//   master modport : drives cyc/stb/we/sel/adr/dat_w, receives ack/dat_r
//   slave  modport : receives cyc/stb/we/sel/adr/dat_w, drives ack/dat_r
interface mprj_wb_guard_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic        ack;
   logic [31:0] dat_r;

   modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/mprj_wb_guard.sv
// Bus-timeout guard between the management core's user-project Wishbone
// master and the user area. Each core request is registered toward the user
// side; the user's ack/data is returned to the core one cycle later. If the
// user never acks within TIMEOUT strobe cycles the guard completes the cycle
// itself with ERR_DATA, pulses timeout_irq and logs the failing address.
// Ports:
//   core_clk, core_rst : clock, asynchronous active-high reset
//   wb_iena            : user return-path enable (0 = ignore user ack/data)
//   m                  : core-side bus (guard acts as slave)
//   u                  : user-side bus (guard acts as master)
//   timeout_irq        : one-cycle pulse per timed-out transaction
//   timeout_count      : saturating count of timed-out transactions
//   err_adr            : address of the most recent timed-out transaction
module mprj_wb_guard #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic               core_clk,
   input  logic               core_rst,
   input  logic               wb_iena,
   mprj_wb_guard_if.slave     m,
   mprj_wb_guard_if.master    u,
   output logic               timeout_irq,
   output logic [7:0]         timeout_count,
   output logic [31:0]        err_adr
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          ack_ok;

   assign ack_ok = u.ack & wb_iena;

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         m.ack         <= 1'b0;
         m.dat_r       <= '0;
         u.cyc         <= 1'b0;
         u.stb         <= 1'b0;
         u.we          <= 1'b0;
         u.sel         <= '0;
         u.adr         <= '0;
         u.dat_w       <= '0;
         timeout_irq   <= 1'b0;
         timeout_count <= '0;
         err_adr       <= '0;
      end else begin
         // ack and irq are single-cycle pulses, asserted only on entry to RESP
         m.ack       <= 1'b0;
         timeout_irq <= 1'b0;
         case (state)
            S_IDLE: begin
               if (m.cyc && m.stb) begin
                  u.we    <= m.we;
                  u.sel   <= m.sel;
                  u.adr   <= m.adr;
                  u.dat_w <= m.dat_w;
                  u.cyc   <= 1'b1;
                  u.stb   <= 1'b1;
                  cnt     <= '0;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (!m.cyc) begin
                  // master abort: silent return, not a timeout
                  u.cyc <= 1'b0;
                  u.stb <= 1'b0;
                  state <= S_IDLE;
               end else if (ack_ok) begin
                  // checked before the timeout so a last-cycle ack still wins
                  m.dat_r <= u.dat_r;
                  m.ack   <= 1'b1;
                  u.cyc   <= 1'b0;
                  u.stb   <= 1'b0;
                  state   <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  m.dat_r     <= ERR_DATA;
                  m.ack       <= 1'b1;
                  u.cyc       <= 1'b0;
                  u.stb       <= 1'b0;
                  timeout_irq <= 1'b1;
                  err_adr     <= u.adr;
                  if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
                  state       <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mprj_wb_guard.sv
// Directed bench for mprj_wb_guard with TIMEOUT=8. The bench plays both the
// core master and the user slave; expected values are hand-derived.
module tb_mprj_wb_guard;

   logic core_clk = 1'b0;
   logic core_rst = 1'b1;
   logic wb_iena  = 1'b1;
   logic timeout_irq;
   logic [7:0]  timeout_count;
   logic [31:0] err_adr;

   mprj_wb_guard_if m_bus ();
   mprj_wb_guard_if u_bus ();

   mprj_wb_guard #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
      .core_clk      (core_clk),
      .core_rst      (core_rst),
      .wb_iena       (wb_iena),
      .m             (m_bus),
      .u             (u_bus),
      .timeout_irq   (timeout_irq),
      .timeout_count (timeout_count),
      .err_adr       (err_adr)
   );

   always #5 core_clk = ~core_clk;

   int n_vec = 0;
   int n_err = 0;

   // results of the last run_txn
   int          ack_cyc;
   int          stb_cycles;
   int          irq_cnt;
   logic [31:0] got_dat;
   logic [31:0] c1_adr, c1_dat;
   logic [3:0]  c1_sel;
   logic        c1_we;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   // Issue one request in cycle 0; the user acks during cycle ack_k (0 = never).
   task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] wdat, input int ack_k, input logic [31:0] rdat);
      ack_cyc = -1; stb_cycles = 0; irq_cnt = 0; got_dat = '0;
      m_bus.cyc = 1'b1; m_bus.stb = 1'b1; m_bus.we = we;
      m_bus.sel = sel; m_bus.adr = adr; m_bus.dat_w = wdat;
      u_bus.dat_r = rdat;
      for (int c = 0; c < 30; c++) begin
         u_bus.ack = (ack_k > 0) && (c == ack_k);
         tick();
         if (c == 0) begin
            c1_adr = u_bus.adr; c1_dat = u_bus.dat_w; c1_sel = u_bus.sel; c1_we = u_bus.we;
         end
         if (u_bus.stb) stb_cycles++;
         if (timeout_irq) irq_cnt++;
         if (m_bus.ack) begin
            ack_cyc = c + 1;
            got_dat = m_bus.dat_r;
            break;
         end
      end
      m_bus.cyc = 1'b0; m_bus.stb = 1'b0; u_bus.ack = 1'b0;
      if (ack_cyc < 0) chk("txn_timeout_bound", 32'hFFFFFFFF, 32'h0);
   endtask

   initial begin
      m_bus.cyc = 0; m_bus.stb = 0; m_bus.we = 0; m_bus.sel = 0; m_bus.adr = 0; m_bus.dat_w = 0;
      u_bus.ack = 0; u_bus.dat_r = 0;
      #12;
      chk("rst_u_cyc", 32'(u_bus.cyc), 0);
      chk("rst_m_ack", 32'(m_bus.ack), 0);
      chk("rst_m_dat", m_bus.dat_r, 0);
      chk("rst_u_adr", u_bus.adr, 0);
      chk("rst_count", 32'(timeout_count), 0);
      chk("rst_irq",   32'(timeout_irq), 0);
      core_rst = 1'b0;
      tick();

      // spurious ack while idle is ignored
      u_bus.ack = 1'b1; u_bus.dat_r = 32'h55555555;
      tick();
      u_bus.ack = 1'b0;
      tick();
      chk("spur_ack",  32'(m_bus.ack), 0);
      chk("spur_dat",  m_bus.dat_r, 0);

      // 1: read, ack 3 cycles after strobe rises
      run_txn(1'b0, 4'hF, 32'h30000000, 32'h0, 4, 32'h12345678);
      chk("t1_ack_cyc", 32'(ack_cyc), 5);
      chk("t1_data",    got_dat, 32'h12345678);
      chk("t1_stb",     32'(stb_cycles), 4);
      chk("t1_count",   32'(timeout_count), 0);

      // 2: write, fields forwarded, single ack
      tick();
      run_txn(1'b1, 4'b0011, 32'h30000004, 32'hA5A5A5A5, 2, 32'h0BADF00D);
      chk("t2_adr",     c1_adr, 32'h30000004);
      chk("t2_sel",     32'(c1_sel), 32'h3);
      chk("t2_dat",     c1_dat, 32'hA5A5A5A5);
      chk("t2_we",      32'(c1_we), 1);
      chk("t2_ack_cyc", 32'(ack_cyc), 3);
      tick();
      chk("t2_single_ack", 32'(m_bus.ack), 0);
      chk("t2_hold_dat",   m_bus.dat_r, 32'h0BADF00D);

      // 3: timeout
      run_txn(1'b0, 4'hF, 32'h30000010, 32'h0, 0, 32'h11111111);
      chk("t3_ack_cyc", 32'(ack_cyc), 9);
      chk("t3_data",    got_dat, 32'hDEADBEEF);
      chk("t3_stb",     32'(stb_cycles), 8);
      chk("t3_irq",     32'(irq_cnt), 1);
      chk("t3_err_adr", err_adr, 32'h30000010);
      chk("t3_count",   32'(timeout_count), 1);
      tick();
      chk("t3_irq_pulse", 32'(timeout_irq), 0);

      // 4: ack in the final REQ cycle wins over timeout
      run_txn(1'b0, 4'hF, 32'h30000020, 32'h0, 8, 32'hCAFEF00D);
      chk("t4_ack_cyc", 32'(ack_cyc), 9);
      chk("t4_data",    got_dat, 32'hCAFEF00D);
      chk("t4_irq",     32'(irq_cnt), 0);
      chk("t4_count",   32'(timeout_count), 1);
      chk("t4_err_adr", err_adr, 32'h30000010);

      // 5: return path disabled, ack ignored
      tick();
      wb_iena = 1'b0;
      run_txn(1'b0, 4'hF, 32'h30000030, 32'h0, 1, 32'h22222222);
      wb_iena = 1'b1;
      chk("t5_ack_cyc", 32'(ack_cyc), 9);
      chk("t5_data",    got_dat, 32'hDEADBEEF);
      chk("t5_irq",     32'(irq_cnt), 1);
      chk("t5_count",   32'(timeout_count), 2);
      chk("t5_err_adr", err_adr, 32'h30000030);

      // 6: master abort in 2nd REQ cycle
      tick();
      m_bus.cyc = 1; m_bus.stb = 1; m_bus.we = 0; m_bus.adr = 32'h30000040;
      tick();                       // cycle 1
      tick();                       // cycle 2
      chk("t6_stb_c2", 32'(u_bus.stb), 1);
      m_bus.cyc = 0; m_bus.stb = 0;
      tick();                       // cycle 3
      chk("t6_cyc_drop", 32'(u_bus.cyc), 0);
      irq_cnt = 0; ack_cyc = 0;
      for (int i = 0; i < 12; i++) begin
         if (m_bus.ack) ack_cyc++;
         if (timeout_irq) irq_cnt++;
         tick();
      end
      chk("t6_no_ack",  32'(ack_cyc), 0);
      chk("t6_no_irq",  32'(irq_cnt), 0);
      chk("t6_count",   32'(timeout_count), 2);

      // 7: asynchronous reset mid-REQ
      m_bus.cyc = 1; m_bus.stb = 1; m_bus.adr = 32'h30000050;
      tick();
      tick();
      chk("t7_stb_pre", 32'(u_bus.stb), 1);
      #2 core_rst = 1'b1;
      #1;
      chk("t7_u_cyc",  32'(u_bus.cyc), 0);
      chk("t7_u_adr",  u_bus.adr, 0);
      chk("t7_m_dat",  m_bus.dat_r, 0);
      chk("t7_count",  32'(timeout_count), 0);
      chk("t7_err_adr", err_adr, 0);
      m_bus.cyc = 0; m_bus.stb = 0;
      tick();
      chk("t7_no_ack", 32'(m_bus.ack), 0);
      core_rst = 1'b0;
      tick();
      run_txn(1'b0, 4'hF, 32'h30000060, 32'h0, 2, 32'h87654321);
      chk("t7_ack_cyc", 32'(ack_cyc), 3);
      chk("t7_data",    got_dat, 32'h87654321);

      // 8: saturation after 300 timeouts
      for (int i = 0; i < 300; i++) begin
         tick();
         run_txn(1'b0, 4'hF, 32'h30001000 + 32'(i), 32'h0, 0, 32'h0);
      end
      chk("t8_count",   32'(timeout_count), 255);
      chk("t8_err_adr", err_adr, 32'h30001000 + 32'd299);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
